syscall_run_ctrl: RTL and testbench
===================================

// Module: syscall_run_ctrl
// PURPOSE
//  Run/halt sequencer for the single-cycle CPU datapath. Consumes decoded syscall,
//  jump and branch-taken flags and drives the PC write enable (out_run).
//  Handles the halt (v0=10) and LED display (v0=34) services, resumes on a GO button
//  edge, and keeps saturating run statistics for the board display.
// PARAMETERS
//  CNT_W     32   width of each statistics counter
//  HALT_CODE 10   $v0 value that requests halt
//  DISP_CODE 34   $v0 value that requests LED display of $a0
// PORTS
//  in_clk          in   1      system clock, all state on rising edge
//  in_rst          in   1      synchronous reset, active-high
//  in_syscall      in   1      current instruction is SYSCALL (from decoder)
//  in_v0           in   32     register $v0 read value
//  in_a0           in   32     register $a0 read value
//  in_jump         in   1      unconditional jump (J/JAL/JR) in current instruction
//  in_branch_taken in   1      conditional branch taken in current instruction
//  in_go           in   1      GO button level, already debounced
//  out_run         out  1      PC/regfile/memory write enable for this cycle
//  out_halted      out  1      1 while in HALT
//  out_led         out  32     last displayed $a0
//  out_cycles      out  CNT_W  executed-instruction count
//  out_jumps       out  CNT_W  executed unconditional-jump count
//  out_branches    out  CNT_W  executed taken-branch count
// BEHAVIOUR
//  Clock/reset: one clock in_clk; reset in_rst synchronous, active-high.
//  Reset: state=RUN, go_q=0, out_led=0, all counters=0, out_halted=0.
//  States: RUN, HALT, RESUME (2-bit encoding, free choice).
//  halt_req = in_syscall & (in_v0 == HALT_CODE); disp_req = in_syscall & (in_v0 == DISP_CODE).
//  out_run (combinational): RUN -> ~halt_req; RESUME -> 1; HALT -> 0.
//   PC must not advance on the halting syscall, so it is re-fetched on resume.
//  go_q <= in_go every cycle in every state. go_edge = in_go & ~go_q.
//  Transitions:
//   RUN: halt_req -> HALT, else stay.
//   HALT: go_edge -> RESUME, else stay.
//   RESUME: -> RUN unconditionally, one cycle only.
//  RESUME ignores in_syscall, so the halting syscall executes once and PC advances.
//  GO held high while entering HALT does not resume; a release then a new press is required.
//  LED: if out_run & disp_req, out_led <= in_a0 at the edge; otherwise hold.
//   Applies in RUN and in RESUME.
//  Other $v0 values: the syscall is a no-op; it executes and is counted.
//  Counters update at the edge, only when out_run=1:
//   out_cycles +1 every run cycle.
//   out_jumps +1 if in_jump.
//   out_branches +1 if in_branch_taken.
//  Each counter saturates at 2^CNT_W-1 and holds; no wrap.
//  in_jump and in_branch_taken both high in one cycle: both counters increment.
//  Reset has priority over every event, including mid-HALT and mid-RESUME; next state is RUN.
//  No output depends combinationally on in_go. out_run depends on in_syscall/in_v0 only in RUN.
// TESTING
//  1. Reset, then 5 cycles of non-syscall, no jump/branch -> out_run=1, out_cycles=5, jumps=branches=0.
//  2. syscall, v0=34, a0=0xDEADBEEF -> next edge out_led=0xDEADBEEF, state RUN, out_cycles +1.
//  3. syscall, v0=10 -> out_run=0 that same cycle; out_halted=1 next; counters frozen for 10 cycles.
//  4. In HALT with go held high since entry -> stays HALT.
//     Release, then press -> RESUME for 1 cycle (out_run=1, syscall ignored), then RUN; cycles +1.
//  5. in_jump & in_branch_taken together for 3 run cycles -> jumps=3, branches=3.
//     With CNT_W=4 and 20 run cycles -> out_cycles=15 (saturated).
//  6. Assert in_rst while in HALT with out_led=0x12 -> next edge RUN, out_led=0, all counters 0.

Source files
------------

// File: rtl/syscall_run_ctrl.sv
// Run/halt sequencer for the single-cycle CPU: gates the PC write enable on halt
// syscalls, latches LED display requests and keeps saturating run statistics.
module syscall_run_ctrl #(
    parameter int CNT_W     = 32,
    parameter int HALT_CODE = 10,
    parameter int DISP_CODE = 34
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_syscall,
    input  logic [31:0]      in_v0,
    input  logic [31:0]      in_a0,
    input  logic             in_jump,
    input  logic             in_branch_taken,
    input  logic             in_go,
    output logic             out_run,
    output logic             out_halted,
    output logic [31:0]      out_led,
    output logic [CNT_W-1:0] out_cycles,
    output logic [CNT_W-1:0] out_jumps,
    output logic [CNT_W-1:0] out_branches
);

    // state  | meaning
    // RUN    | executing; a halt syscall blocks the PC write and enters HALT
    // HALT   | PC frozen, waiting for a fresh GO press
    // RESUME | one cycle that re-executes the halting syscall as a no-op

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALT   = 2'b01,
        ST_RESUME = 2'b10
    } state_t;

    localparam logic [31:0] HALT_V0 = 32'(HALT_CODE);
    localparam logic [31:0] DISP_V0 = 32'(DISP_CODE);

    state_t state, state_nxt;
    logic   go_q;
    logic   halt_req;
    logic   disp_req;
    logic   go_edge;

    assign halt_req = in_syscall && (in_v0 == HALT_V0);
    assign disp_req = in_syscall && (in_v0 == DISP_V0);
    assign go_edge  = in_go && !go_q;

    always_comb begin
        state_nxt = state;
        out_run   = 1'b0;
        case (state)
            ST_RUN: begin
                out_run = !halt_req;
                if (halt_req) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (go_edge) state_nxt = ST_RESUME;
            end
            ST_RESUME: begin
                out_run   = 1'b1;
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign out_halted = (state == ST_HALT);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= ST_RUN;
            go_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            go_q  <= in_go;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_led <= '0;
        end else if (out_run && disp_req) begin
            out_led <= in_a0;
        end
    end

    // Counters stick at all-ones so a long run never reads as a short one.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_cycles   <= '0;
            out_jumps    <= '0;
            out_branches <= '0;
        end else if (out_run) begin
            if (out_cycles != '1) out_cycles <= out_cycles + 1'b1;
            if (in_jump && (out_jumps != '1)) out_jumps <= out_jumps + 1'b1;
            if (in_branch_taken && (out_branches != '1)) out_branches <= out_branches + 1'b1;
        end
    end

endmodule

// File: tb/tb_syscall_run_ctrl.sv
// Directed bench for syscall_run_ctrl: full-width instance for the run/halt/LED
// sequence and a 4-bit-counter instance for saturation.
module tb_syscall_run_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, syscall, jump, branch, go;
    logic [31:0] v0, a0;
    logic        run, halted;
    logic [31:0] led, cycles, jumps, branches;

    logic        s_rst, s_jump, s_branch;
    logic        s_run, s_halted;
    logic [31:0] s_led;
    logic [3:0]  s_cycles, s_jumps, s_branches;

    int n_tests = 0;
    int n_fail  = 0;

    syscall_run_ctrl dut (
        .in_clk(clk), .in_rst(rst), .in_syscall(syscall), .in_v0(v0), .in_a0(a0),
        .in_jump(jump), .in_branch_taken(branch), .in_go(go),
        .out_run(run), .out_halted(halted), .out_led(led),
        .out_cycles(cycles), .out_jumps(jumps), .out_branches(branches)
    );

    syscall_run_ctrl #(.CNT_W(4)) dut_sat (
        .in_clk(clk), .in_rst(s_rst), .in_syscall(1'b0), .in_v0(32'd0), .in_a0(32'd0),
        .in_jump(s_jump), .in_branch_taken(s_branch), .in_go(1'b0),
        .out_run(s_run), .out_halted(s_halted), .out_led(s_led),
        .out_cycles(s_cycles), .out_jumps(s_jumps), .out_branches(s_branches)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; syscall = 1'b0; v0 = '0; a0 = '0; jump = 1'b0; branch = 1'b0; go = 1'b0;
        s_rst = 1'b1; s_jump = 1'b0; s_branch = 1'b0;
        step(2);
        rst = 1'b0;
        #1;
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_led", led, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_run", {31'd0, run}, 32'd1);

        step(5);
        chk("idle_cycles", cycles, 32'd5);
        chk("idle_jumps", jumps, 32'd0);
        chk("idle_branches", branches, 32'd0);

        syscall = 1'b1; v0 = 32'd34; a0 = 32'hDEADBEEF;
        #1;
        chk("disp_run", {31'd0, run}, 32'd1);
        step(1);
        chk("disp_led", led, 32'hDEADBEEF);
        chk("disp_halted", {31'd0, halted}, 32'd0);
        chk("disp_cycles", cycles, 32'd6);

        go = 1'b1;
        v0 = 32'd10; a0 = 32'h0000_0055;
        #1;
        chk("halt_run_same_cycle", {31'd0, run}, 32'd0);
        step(1);
        chk("halt_entered", {31'd0, halted}, 32'd1);
        step(10);
        chk("halt_go_held", {31'd0, halted}, 32'd1);
        chk("halt_run", {31'd0, run}, 32'd0);
        chk("halt_cycles_frozen", cycles, 32'd6);
        chk("halt_led_frozen", led, 32'hDEADBEEF);

        go = 1'b0;
        step(1);
        chk("halt_go_release", {31'd0, halted}, 32'd1);
        go = 1'b1;
        step(1);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_run_ignores_sc", {31'd0, run}, 32'd1);
        step(1);
        chk("resume_cycles", cycles, 32'd7);
        chk("back_in_run_halt_sc", {31'd0, run}, 32'd0);
        syscall = 1'b0; go = 1'b0;
        #1;
        chk("run_no_sc", {31'd0, run}, 32'd1);

        syscall = 1'b1; v0 = 32'd5;
        step(1);
        chk("noop_sc_cycles", cycles, 32'd8);
        chk("noop_sc_halted", {31'd0, halted}, 32'd0);
        syscall = 1'b0;

        jump = 1'b1; branch = 1'b1;
        step(3);
        chk("jb_jumps", jumps, 32'd3);
        chk("jb_branches", branches, 32'd3);
        chk("jb_cycles", cycles, 32'd11);
        jump = 1'b0;
        step(1);
        chk("branch_only", branches, 32'd4);
        chk("jump_hold", jumps, 32'd3);
        branch = 1'b0;

        syscall = 1'b1; v0 = 32'd34; a0 = 32'h12;
        step(1);
        chk("led_12", led, 32'h12);
        v0 = 32'd10;
        step(1);
        chk("halt_again", {31'd0, halted}, 32'd1);
        syscall = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        chk("rst_halt_state", {31'd0, halted}, 32'd0);
        chk("rst_halt_led", led, 32'd0);
        chk("rst_halt_cycles", cycles, 32'd0);
        chk("rst_halt_jumps", jumps, 32'd0);
        chk("rst_halt_branches", branches, 32'd0);

        s_rst = 1'b0; s_jump = 1'b1; s_branch = 1'b1;
        step(14);
        chk("sat_cycles_14", {28'd0, s_cycles}, 32'd14);
        step(6);
        chk("sat_cycles", {28'd0, s_cycles}, 32'd15);
        chk("sat_jumps", {28'd0, s_jumps}, 32'd15);
        chk("sat_branches", {28'd0, s_branches}, 32'd15);
        chk("sat_run", {31'd0, s_run}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
